// File: rtl/countdown_timer_5b.sv
// Loadable down-counter with a start/busy/done handshake.
// START loads LOAD_VAL in IDLE, EN-gated decrements in RUN, and a one-cycle FIN raises DONE.
module countdown_timer_5b #(
    parameter int unsigned P = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [P-1:0] LOAD_VAL,
    input  logic         EN,
    input  logic         ABORT,
    output logic [P-1:0] Y,
    output logic         BUSY,
    output logic         DONE,
    output logic         ZERO
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t state;

    // BUSY/DONE are registered alongside the state so they decode the next state exactly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            Y     <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            BUSY <= 1'b0;
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        Y <= LOAD_VAL;
                        if (LOAD_VAL == '0) begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end else begin
                            state <= RUN;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ABORT) begin
                        Y     <= '0;
                        state <= IDLE;
                    end else if (EN) begin
                        Y <= Y - P'(1);
                        // Leaving at Y==1 keeps the counter from ever wrapping below zero.
                        if (Y == P'(1)) begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end else begin
                            BUSY <= 1'b1;
                        end
                    end else begin
                        BUSY <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Y     <= '0;
                end
            endcase
        end
    end

    assign ZERO = (Y == '0);

endmodule

// File: tb/tb_countdown_timer_5b.sv
// Self-checking bench for countdown_timer_5b: directed vector table, corner sequences,
// and randomized traffic compared against a behavioural countdown model.
module tb_countdown_timer_5b;

    localparam int unsigned P = 5;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [P-1:0] LOAD_VAL;
    logic         EN;
    logic         ABORT;
    logic [P-1:0] Y;
    logic         BUSY;
    logic         DONE;
    logic         ZERO;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer_5b #(.P(P)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .LOAD_VAL (LOAD_VAL),
        .EN       (EN),
        .ABORT    (ABORT),
        .Y        (Y),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ZERO     (ZERO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         start;
        logic [P-1:0] load;
        logic         en;
        logic         abort;
        logic [P-1:0] y;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: remaining count plus "counting" / "just finished" flags.
    int m_y;
    bit m_run;
    bit m_fin;

    function automatic void add(input logic st, input int ld, input logic en, input logic ab,
                                input int y, input logic busy, input logic done);
        vec_t v;
        v.start = st;
        v.load  = P'(ld);
        v.en    = en;
        v.abort = ab;
        v.y     = P'(y);
        v.busy  = busy;
        v.done  = done;
        vecs.push_back(v);
    endfunction

    function automatic void model_step(input bit st, input int ld, input bit en, input bit ab);
        if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_run) begin
            if (ab) begin
                m_run = 1'b0;
                m_y   = 0;
            end else if (en) begin
                m_y = m_y - 1;
                if (m_y == 0) begin
                    m_run = 1'b0;
                    m_fin = 1'b1;
                end
            end
        end else if (st) begin
            m_y = ld;
            if (ld == 0) m_fin = 1'b1;
            else         m_run = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int y, input logic busy, input logic done);
        chk({tag, ".Y"},    32'(Y),    32'(y));
        chk({tag, ".BUSY"}, 32'(BUSY), 32'(busy));
        chk({tag, ".DONE"}, 32'(DONE), 32'(done));
        chk({tag, ".ZERO"}, 32'(ZERO), 32'(y == 0));
    endtask

    task automatic drive(input logic st, input int ld, input logic en, input logic ab);
        START    = st;
        LOAD_VAL = P'(ld);
        EN       = en;
        ABORT    = ab;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int dones;
        RST = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0);
        #12;
        check_out("reset", 0, 1'b0, 1'b0);
        RST = 1'b0;
        tick();
        check_out("idle_after_reset", 0, 1'b0, 1'b0);

        // Nominal count of 5
        add(1, 5, 0, 0, 5, 1, 0);
        add(0, 0, 1, 0, 4, 1, 0);
        add(0, 0, 1, 0, 3, 1, 0);
        add(0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0);
        // EN gating 1,0,0,1,1,0,1
        add(1, 4, 0, 0, 4, 1, 0);
        add(0, 0, 1, 0, 3, 1, 0);
        add(0, 0, 0, 0, 3, 1, 0);
        add(0, 0, 0, 0, 3, 1, 0);
        add(0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Zero-length load
        add(1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Abort with EN at Y=7, abort in IDLE, ignored START in RUN and FIN
        add(1, 9, 0, 0, 9, 1, 0);
        add(0, 0, 1, 0, 8, 1, 0);
        add(0, 0, 1, 0, 7, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(1, 3, 0, 0, 3, 1, 0);
        add(1, 20, 0, 0, 3, 1, 0);
        add(1, 20, 1, 0, 2, 1, 0);
        add(1, 20, 1, 0, 1, 1, 0);
        add(1, 20, 1, 0, 0, 0, 1);
        add(1, 20, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, int'(vecs[i].load), vecs[i].en, vecs[i].abort);
            tick();
            check_out($sformatf("vec%0d", i), int'(vecs[i].y), vecs[i].busy, vecs[i].done);
        end

        // Maximum load: 31 decrements, no wrap, exactly one DONE
        drive(1'b1, 31, 1'b1, 1'b0);
        tick();
        check_out("max_load", 31, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        dones = 0;
        for (int j = 1; j <= 31; j++) begin
            tick();
            if (DONE) dones++;
            check_out($sformatf("max_step%0d", j), 31 - j, j < 31, j == 31);
        end
        tick();
        if (DONE) dones++;
        check_out("max_idle", 0, 1'b0, 1'b0);
        chk("max_done_count", 32'(dones), 32'd1);

        // Back-to-back: START held high with LOAD_VAL=2 gives period 4
        drive(1'b1, 2, 1'b1, 1'b0);
        for (int j = 0; j < 12; j++) begin
            tick();
            case (j % 4)
                0:       check_out($sformatf("b2b%0d", j), 2, 1'b1, 1'b0);
                1:       check_out($sformatf("b2b%0d", j), 1, 1'b1, 1'b0);
                2:       check_out($sformatf("b2b%0d", j), 0, 1'b0, 1'b1);
                default: check_out($sformatf("b2b%0d", j), 0, 1'b0, 1'b0);
            endcase
            chk("b2b_busy_and_done", 32'(BUSY & DONE), 32'd0);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        tick();
        check_out("b2b_idle", 0, 1'b0, 1'b0);

        // Asynchronous reset between edges in the middle of a count at Y=13
        drive(1'b1, 13, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        tick();
        check_out("pre_reset", 13, 1'b1, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        check_out("async_reset", 0, 1'b0, 1'b0);
        RST = 1'b0;
        drive(1'b1, 3, 1'b0, 1'b0);
        tick();
        check_out("start_after_reset", 3, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        check_out("abort_to_idle", 0, 1'b0, 1'b0);

        // Randomized traffic against the behavioural model
        m_y   = 0;
        m_run = 1'b0;
        m_fin = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bit st, en, ab;
            int ld, r;
            st = ($urandom_range(0, 2) == 0);
            r  = int'($urandom_range(0, 9));
            ld = (r == 0) ? 0 : (r == 1) ? 31 : int'($urandom_range(1, 8));
            en = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 19) == 0);
            drive(st, ld, en, ab);
            model_step(st, ld, en, ab);
            tick();
            check_out($sformatf("rand%0d", c), m_y, m_run, m_fin);
            chk("rand_busy_and_done", 32'(BUSY & DONE), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
